// File: rtl/arm_pkg.sv
// Shared execute-stage definitions: command encodings, NZCV bit positions
// and the flag vector type used by the status flag unit and its ALU.
package arm_pkg;

    typedef logic [3:0] exe_cmd_t;
    typedef logic [3:0] nzcv_t;

    localparam exe_cmd_t EXE_MOV = 4'b0001;
    localparam exe_cmd_t EXE_MVN = 4'b1001;
    localparam exe_cmd_t EXE_ADD = 4'b0010;
    localparam exe_cmd_t EXE_ADC = 4'b0011;
    localparam exe_cmd_t EXE_SUB = 4'b0100;
    localparam exe_cmd_t EXE_SBC = 4'b0101;
    localparam exe_cmd_t EXE_AND = 4'b0110;
    localparam exe_cmd_t EXE_ORR = 4'b0111;
    localparam exe_cmd_t EXE_EOR = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Pack individual flag bits into the architectural {N,Z,C,V} order.
    function automatic nzcv_t pack_nzcv(input logic n, input logic z,
                                        input logic c, input logic v);
        nzcv_t f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/status_flag_unit_if.sv
// EXE-stage bundle between the pipeline control (master) and the status
// flag unit (slave): instruction inputs in, flags and EXE/MEM register out.
interface status_flag_unit_if
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    exe_cmd_t         exe_cmd;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             s_bit;
    logic             freeze;
    logic             flush;
    nzcv_t            nzcv;
    nzcv_t            nzcv_fwd;
    logic             out_valid;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, exe_cmd, op_a, op_b, s_bit, freeze, flush,
        input  nzcv, nzcv_fwd, out_valid, result
    );

    modport slave (
        input  in_valid, exe_cmd, op_a, op_b, s_bit, freeze, flush,
        output nzcv, nzcv_fwd, out_valid, result
    );

endinterface

// File: rtl/alu_flags.sv
// Combinational data-path ALU: produces the operation result and the
// candidate NZCV vector. Logic ops and moves pass the current C and V
// through; unknown command codes report flag_op=0 and a zero result.
module alu_flags
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  exe_cmd_t         cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] r,
    output nzcv_t            nzcv_new,
    output logic             flag_op
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] addend;
    logic             carry;
    logic [WIDTH:0]   sum;
    logic             arith_v;
    logic             c_flag;
    logic             v_flag;

    // Select the effective addend and carry-in; subtraction is a + ~b + carry.
    always_comb begin
        addend = b;
        carry  = 1'b0;
        case (cmd)
            EXE_ADD: begin
                addend = b;
                carry  = 1'b0;
            end
            EXE_ADC: begin
                addend = b;
                carry  = c_in;
            end
            EXE_SUB: begin
                addend = ~b;
                carry  = 1'b1;
            end
            EXE_SBC: begin
                addend = ~b;
                carry  = c_in;
            end
            default: begin
                addend = b;
                carry  = 1'b0;
            end
        endcase
    end

    assign sum     = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, carry};
    assign arith_v = (a[MSB] == addend[MSB]) & (sum[MSB] != a[MSB]);

    // Result mux and C/V selection; only arithmetic ops touch C and V.
    always_comb begin
        r       = '0;
        c_flag  = c_in;
        v_flag  = v_in;
        flag_op = 1'b0;
        case (cmd)
            EXE_MOV: begin
                r       = b;
                flag_op = 1'b1;
            end
            EXE_MVN: begin
                r       = ~b;
                flag_op = 1'b1;
            end
            EXE_AND: begin
                r       = a & b;
                flag_op = 1'b1;
            end
            EXE_ORR: begin
                r       = a | b;
                flag_op = 1'b1;
            end
            EXE_EOR: begin
                r       = a ^ b;
                flag_op = 1'b1;
            end
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
                r       = sum[WIDTH-1:0];
                c_flag  = sum[WIDTH];
                v_flag  = arith_v;
                flag_op = 1'b1;
            end
            default: begin
                r       = '0;
                flag_op = 1'b0;
            end
        endcase
    end

    assign nzcv_new = pack_nzcv(r[MSB], (r == '0), c_flag, v_flag);

endmodule

// File: rtl/status_flag_unit.sv
// Execute-stage NZCV producer: runs the ALU, owns the architectural status
// register and the EXE/MEM result register, and forwards the next flag
// value combinationally so decode can condition-check in the same cycle.
module status_flag_unit
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    status_flag_unit_if.slave bus
);

    nzcv_t            nzcv_q;
    nzcv_t            nzcv_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic [WIDTH-1:0] alu_r;
    nzcv_t            alu_nzcv;
    logic             alu_flag_op;
    logic             commit;
    logic             flag_load;

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_alu_flags (
        .cmd      (bus.exe_cmd),
        .a        (bus.op_a),
        .b        (bus.op_b),
        .c_in     (nzcv_q[FLAG_C]),
        .v_in     (nzcv_q[FLAG_V]),
        .r        (alu_r),
        .nzcv_new (alu_nzcv),
        .flag_op  (alu_flag_op)
    );

    // A flush squashes the update even when freeze is also high.
    assign commit    = bus.in_valid & ~bus.freeze & ~bus.flush;
    assign flag_load = commit & bus.s_bit & alu_flag_op;

    // Next status register value; also what decode sees as nzcv_fwd.
    always_comb begin
        nzcv_d = nzcv_q;
        if (flag_load) begin
            nzcv_d = alu_nzcv;
        end
    end

    // Next EXE/MEM register contents; the whole register holds under freeze.
    always_comb begin
        result_d    = result_q;
        out_valid_d = out_valid_q;
        if (!bus.freeze) begin
            result_d    = alu_r;
            out_valid_d = bus.in_valid & ~bus.flush;
        end
    end

    // Status register and pipeline register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzcv_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            nzcv_q      <= nzcv_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.nzcv      = nzcv_q;
    assign bus.nzcv_fwd  = nzcv_d;
    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit: directed scenarios followed by random
// instructions, all checked against an arithmetic reference model.
module tb_status_flag_unit;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk;
    logic rst;

    int total;
    int bad;

    logic [3:0]  m_nzcv;
    logic [31:0] m_result;
    logic        m_valid;
    logic [3:0]  seen_fwd;
    logic [3:0]  seen_pre;

    status_flag_unit_if #(.WIDTH(W)) bus ();

    status_flag_unit #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

    // Reference ALU written from integer arithmetic on the operand values.
    function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] flags,
                                    output bit op, output logic [31:0] r,
                                    output logic [3:0] nf);
        longint ua, ub, sa, sb, full, sfull, extra;
        bit c, v;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = $signed(a);
        sb = $signed(b);
        c  = flags[1];
        v  = flags[0];
        op = 1'b1;
        r  = '0;
        case (cmd)
            4'h1: r = b;
            4'h9: r = ~b;
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = a ^ b;
            4'h2, 4'h3: begin
                extra = (cmd == 4'h3) ? longint'(flags[1]) : 64'sd0;
                full  = ua + ub + extra;
                sfull = sa + sb + extra;
                r     = full[31:0];
                c     = (full > 64'sd4294967295);
                v     = (sfull > SMAX) || (sfull < SMIN);
            end
            4'h4, 4'h5: begin
                extra = (cmd == 4'h5) ? longint'(!flags[1]) : 64'sd0;
                full  = ua - ub - extra;
                sfull = sa - sb - extra;
                r     = full[31:0];
                c     = (ua >= ub + extra);
                v     = (sfull > SMAX) || (sfull < SMIN);
            end
            default: begin
                op = 1'b0;
                r  = '0;
            end
        endcase
        nf = {r[31], (r == 32'd0), c, v};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one EXE cycle starting at a falling edge, check the forwarded
    // flags before the edge and the registered outputs after it.
    task automatic applyStimulus(input string tag, input bit v, input logic [3:0] cmd,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit s, input bit fz, input bit fl);
        bit          op;
        bit          load;
        logic [31:0] r;
        logic [3:0]  nf;
        bus.in_valid = v;
        bus.exe_cmd  = cmd;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.s_bit    = s;
        bus.freeze   = fz;
        bus.flush    = fl;
        #1;
        ref_alu(cmd, a, b, m_nzcv, op, r, nf);
        load     = v && !fz && !fl && s && op;
        seen_fwd = bus.nzcv_fwd;
        seen_pre = bus.nzcv;
        checkOutput({tag, ".fwd"}, {28'b0, bus.nzcv_fwd}, {28'b0, (load ? nf : m_nzcv)});
        @(posedge clk);
        if (load) m_nzcv = nf;
        if (!fz) begin
            m_result = r;
            m_valid  = v && !fl;
        end
        @(negedge clk);
        checkOutput({tag, ".nzcv"},  {28'b0, bus.nzcv},      {28'b0, m_nzcv});
        checkOutput({tag, ".res"},   bus.result,             m_result);
        checkOutput({tag, ".valid"}, {31'b0, bus.out_valid}, {31'b0, m_valid});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        total    = 0;
        bad      = 0;
        m_nzcv   = 4'b0000;
        m_result = 32'd0;
        m_valid  = 1'b0;
        seen_fwd = 4'b0000;
        seen_pre = 4'b0000;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.exe_cmd  = 4'h0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.s_bit    = 1'b0;
        bus.freeze   = 1'b0;
        bus.flush    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset.nzcv",  {28'b0, bus.nzcv},      32'd0);
        checkOutput("reset.res",   bus.result,             32'd0);
        checkOutput("reset.valid", {31'b0, bus.out_valid}, 32'd0);
        rst = 1'b0;

        $display("[TB] directed arithmetic");
        applyStimulus("subs55", 1, 4'h4, 32'd5, 32'd5, 1, 0, 0);
        checkOutput("subs55.lit", {28'b0, bus.nzcv}, 32'b0110);
        checkOutput("subs55.res.lit", bus.result, 32'd0);
        applyStimulus("sub56", 1, 4'h4, 32'd5, 32'd6, 0, 0, 0);
        checkOutput("sub56.res.lit", bus.result, 32'hFFFF_FFFF);
        checkOutput("sub56.lit", {28'b0, bus.nzcv}, 32'b0110);
        applyStimulus("adds_ovf", 1, 4'h2, 32'h7FFF_FFFF, 32'd1, 1, 0, 0);
        checkOutput("adds_ovf.lit", {28'b0, bus.nzcv}, 32'b1001);
        applyStimulus("adds_wrap", 1, 4'h2, 32'hFFFF_FFFF, 32'd1, 1, 0, 0);
        checkOutput("adds_wrap.lit", {28'b0, bus.nzcv}, 32'b0110);
        applyStimulus("adc00", 1, 4'h3, 32'd0, 32'd0, 0, 0, 0);
        checkOutput("adc00.res.lit", bus.result, 32'd1);

        $display("[TB] logic keeps C and V");
        applyStimulus("subs_cv", 1, 4'h4, 32'h8000_0000, 32'd1, 1, 0, 0);
        checkOutput("subs_cv.lit", {28'b0, bus.nzcv}, 32'b0011);
        applyStimulus("ands", 1, 4'h6, 32'h0000_00F0, 32'h0000_000F, 1, 0, 0);
        checkOutput("ands.lit", {28'b0, bus.nzcv}, 32'b0111);

        $display("[TB] freeze and flush");
        for (int i = 0; i < 3; i++) begin
            applyStimulus("frz_adcs", 1, 4'h3, 32'd1, 32'd1, 1, 1, 0);
        end
        checkOutput("frz.nzcv.lit", {28'b0, bus.nzcv}, 32'b0111);
        checkOutput("frz.res.lit", bus.result, 32'd0);
        applyStimulus("rel_adcs", 1, 4'h3, 32'd1, 32'd1, 1, 0, 0);
        checkOutput("rel.res.lit", bus.result, 32'd3);
        checkOutput("rel.nzcv.lit", {28'b0, bus.nzcv}, 32'b0000);
        applyStimulus("flush_subs", 1, 4'h4, 32'd1, 32'd2, 1, 0, 1);
        checkOutput("flush.nzcv.lit", {28'b0, bus.nzcv}, 32'b0000);
        checkOutput("flush.valid.lit", {31'b0, bus.out_valid}, 32'd0);
        applyStimulus("mov5", 1, 4'h1, 32'd0, 32'd5, 0, 0, 0);
        applyStimulus("frz_flush", 1, 4'h2, 32'h7FFF_FFFF, 32'd1, 1, 1, 1);
        checkOutput("frzfl.nzcv.lit", {28'b0, bus.nzcv}, 32'b0000);
        checkOutput("frzfl.res.lit", bus.result, 32'd5);
        checkOutput("frzfl.valid.lit", {31'b0, bus.out_valid}, 32'd1);

        $display("[TB] forwarding");
        applyStimulus("cmp34", 1, 4'h4, 32'd3, 32'd4, 1, 0, 0);
        checkOutput("cmp.fwd.lit", {28'b0, seen_fwd}, 32'b1000);
        checkOutput("cmp.pre.lit", {28'b0, seen_pre}, 32'b0000);
        checkOutput("cmp.nzcv.lit", {28'b0, bus.nzcv}, 32'b1000);

        $display("[TB] reset mid-stream");
        bus.in_valid = 1'b1;
        bus.exe_cmd  = 4'h4;
        bus.op_a     = 32'd5;
        bus.op_b     = 32'd5;
        bus.s_bit    = 1'b1;
        bus.freeze   = 1'b0;
        bus.flush    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async.nzcv",  {28'b0, bus.nzcv},      32'd0);
        checkOutput("rst_async.valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_async.res",   bus.result,             32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_hold.nzcv",  {28'b0, bus.nzcv},      32'd0);
        checkOutput("rst_hold.valid", {31'b0, bus.out_valid}, 32'd0);
        rst      = 1'b0;
        m_nzcv   = 4'b0000;
        m_result = 32'd0;
        m_valid  = 1'b0;

        $display("[TB] random instructions");
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 3) != 0),
                          4'($urandom_range(0, 15)),
                          pick_operand(), pick_operand(),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
